// File: rtl/vga_pkg.sv
// Shared timing defaults, colour formats and pixel expansion helpers for the VGA tile engine.
package vga_pkg;

    localparam int H_TOTAL_DEF  = 800;
    localparam int V_TOTAL_DEF  = 525;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int HS_START_DEF = 656;
    localparam int HS_END_DEF   = 752;
    localparam int VS_START_DEF = 490;
    localparam int VS_END_DEF   = 492;

    typedef enum logic {
        FMT_RGB332 = 1'b0,
        FMT_RGB565 = 1'b1
    } fmt_e;

    // Bit replication spreads each channel over the full 0..255 range.
    function automatic logic [23:0] expand_rgb332(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
    endfunction

    function automatic logic [23:0] expand_rgb565(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/vram_sdp.sv
// Single-clock simple-dual-port RAM with registered, read-first read port.
module vram_sdp #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Non-blocking read and write on the same edge give old data on a collision.
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[raddr];
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vga_tile_vram.sv
// VGA scan-out engine: timing generator, frame-locked scrolling tile VRAM and colour expansion.
module vga_tile_vram
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int HS_START    = HS_START_DEF,
    parameter int HS_END      = HS_END_DEF,
    parameter int VS_START    = VS_START_DEF,
    parameter int VS_END      = VS_END_DEF,
    parameter bit SYNC_NEG    = 1'b1,
    parameter int CNT_WIDTH   = 10,
    parameter int PIX_BITS    = 8,
    parameter int SCALE_SHIFT = 4,
    parameter int ADDR_H_BITS = 6,
    parameter int ADDR_V_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          data_address,
    input  logic [PIX_BITS-1:0]  data_din,
    input  logic                 data_we,
    output logic [31:0]          data_length,
    input  logic [CNT_WIDTH-1:0] offset_h,
    input  logic [CNT_WIDTH-1:0] offset_v,
    input  logic                 offset_load,
    output logic                 vsync_irq,
    output logic [15:0]          frame_count,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vga_de,
    output logic [7:0]           vga_r,
    output logic [7:0]           vga_g,
    output logic [7:0]           vga_b
);

    localparam int AW = ADDR_H_BITS + ADDR_V_BITS;
    localparam logic [31:0] LENGTH = 32'(2 ** AW);
    localparam fmt_e FMT = (PIX_BITS == 16) ? FMT_RGB565 : FMT_RGB332;
    localparam logic [CNT_WIDTH-1:0] H_LAST = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] V_LAST = CNT_WIDTH'(V_TOTAL - 1);

    logic [CNT_WIDTH-1:0] count_h_q, count_h_d, count_v_q, count_v_d;
    logic [CNT_WIDTH-1:0] shadow_h_q, shadow_h_d, shadow_v_q, shadow_v_d;
    logic [CNT_WIDTH-1:0] act_h_q, act_h_d, act_v_q, act_v_d;
    logic [15:0]          frame_count_q, frame_count_d;
    logic                 frame_start, line_end;

    logic [CNT_WIDTH-1:0] vx_p1_q, vx_p1_d, vy_p1_q, vy_p1_d;
    logic                 hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d, de_p1_q, de_p1_d;
    logic                 hs_p2_q, vs_p2_q, de_p2_q;
    logic                 hs_p3_q, hs_p3_d, vs_p3_q, vs_p3_d, de_p3_q;
    logic [23:0]          rgb_p3_q, rgb_p3_d, rgb_exp;

    logic [AW-1:0]        rd_addr;
    logic [PIX_BITS-1:0]  rd_data;
    logic [15:0]          pix16;
    logic                 wr_en;
    logic                 unused_bits;

    always_comb begin
        frame_start = (count_h_q == '0) && (count_v_q == '0);
        line_end    = (count_h_q == H_LAST);
        count_h_d   = line_end ? '0 : count_h_q + 1'b1;
        count_v_d   = count_v_q;
        if (line_end) begin
            count_v_d = (count_v_q == V_LAST) ? '0 : count_v_q + 1'b1;
        end

        shadow_h_d = offset_load ? offset_h : shadow_h_q;
        shadow_v_d = offset_load ? offset_v : shadow_v_q;
        // Using the _d value lets pixel (0,0) already see the offset for the new frame.
        act_h_d = frame_start ? shadow_h_d : act_h_q;
        act_v_d = frame_start ? shadow_v_d : act_v_q;

        vsync_irq     = (count_h_q == '0) && (count_v_q == CNT_WIDTH'(V_ACTIVE));
        frame_count_d = frame_count_q + 16'(vsync_irq);

        // Stage 1: scrolled virtual coordinates and raw timing flags
        vx_p1_d = count_h_q + act_h_d;
        vy_p1_d = count_v_q + act_v_d;
        hs_p1_d = (count_h_q >= CNT_WIDTH'(HS_START)) && (count_h_q < CNT_WIDTH'(HS_END));
        vs_p1_d = (count_v_q >= CNT_WIDTH'(VS_START)) && (count_v_q < CNT_WIDTH'(VS_END));
        de_p1_d = (count_h_q < CNT_WIDTH'(H_ACTIVE)) && (count_v_q < CNT_WIDTH'(V_ACTIVE));

        // Stage 3: colour expansion and pin polarity
        pix16    = 16'(rd_data);
        rgb_exp  = (FMT == FMT_RGB565) ? expand_rgb565(pix16) : expand_rgb332(pix16[7:0]);
        rgb_p3_d = de_p2_q ? rgb_exp : '0;
        hs_p3_d  = hs_p2_q ^ SYNC_NEG;
        vs_p3_d  = vs_p2_q ^ SYNC_NEG;
    end

    // Stage 2: cell address from the scaled, wrapped coordinates
    assign rd_addr     = {vy_p1_q[SCALE_SHIFT +: ADDR_V_BITS], vx_p1_q[SCALE_SHIFT +: ADDR_H_BITS]};
    assign wr_en       = data_we && (data_address < LENGTH);
    assign unused_bits = ^{vx_p1_q, vy_p1_q, pix16};

    vram_sdp #(
        .AW(AW),
        .DW(PIX_BITS)
    ) u_vram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(data_address[AW-1:0]),
        .wdata(data_din),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_h_q     <= '0;
            count_v_q     <= '0;
            shadow_h_q    <= '0;
            shadow_v_q    <= '0;
            act_h_q       <= '0;
            act_v_q       <= '0;
            frame_count_q <= '0;
            vx_p1_q       <= '0;
            vy_p1_q       <= '0;
            hs_p1_q       <= 1'b0;
            vs_p1_q       <= 1'b0;
            de_p1_q       <= 1'b0;
            hs_p2_q       <= 1'b0;
            vs_p2_q       <= 1'b0;
            de_p2_q       <= 1'b0;
            hs_p3_q       <= SYNC_NEG;
            vs_p3_q       <= SYNC_NEG;
            de_p3_q       <= 1'b0;
            rgb_p3_q      <= '0;
        end else begin
            count_h_q     <= count_h_d;
            count_v_q     <= count_v_d;
            shadow_h_q    <= shadow_h_d;
            shadow_v_q    <= shadow_v_d;
            act_h_q       <= act_h_d;
            act_v_q       <= act_v_d;
            frame_count_q <= frame_count_d;
            vx_p1_q       <= vx_p1_d;
            vy_p1_q       <= vy_p1_d;
            hs_p1_q       <= hs_p1_d;
            vs_p1_q       <= vs_p1_d;
            de_p1_q       <= de_p1_d;
            hs_p2_q       <= hs_p1_q;
            vs_p2_q       <= vs_p1_q;
            de_p2_q       <= de_p1_q;
            hs_p3_q       <= hs_p3_d;
            vs_p3_q       <= vs_p3_d;
            de_p3_q       <= de_p2_q;
            rgb_p3_q      <= rgb_p3_d;
        end
    end

    assign data_length = LENGTH;
    assign frame_count = frame_count_q;
    assign vga_hs      = hs_p3_q;
    assign vga_vs      = vs_p3_q;
    assign vga_de      = de_p3_q;
    assign vga_r       = rgb_p3_q[23:16];
    assign vga_g       = rgb_p3_q[15:8];
    assign vga_b       = rgb_p3_q[7:0];

endmodule
